board_lock_clear: RTL and testbench
===================================

// Module: board_lock_clear
// PURPOSE
//  Consumer end of the falling-piece interface: takes the landed piece from CurrBlock (fell + currBlocks),
//  merges it into the settled board, clears full rows one at a time, and drives fallenBlocks back to CurrBlock.
//  Closes the loop with Spawn (next piece), lineBreak (rows cleared) and gameOver. Runs on frame_clk.
// PARAMETERS
//  ROWS        20  board height; row 0 = top, row ROWS-1 = bottom
//  COLS        10  board width; bit c of a row = column c
//  SPAWN_ROWS  2   top rows that must be empty after a lock or the game ends
//  LINE_W      16  width of the total-lines counter
// PORTS
//  frame_clk     in   1              sole clock, rising edge
//  Reset         in   1              asynchronous, active-high
//  startGame     in   1              pulse: clear board and counters, request first piece
//  fell          in   1              pulse: current piece has landed; sampled only in IDLE
//  currBlocks    in   [COLS-1:0]x[ROWS] landed piece bitmap, valid in the cycle fell=1
//  fallenBlocks  out  [COLS-1:0]x[ROWS] settled board (registered)
//  Spawn         out  1              one-cycle pulse: spawn the next piece
//  lineBreak     out  1              one-cycle pulse, coincident with Spawn, if >=1 row cleared in this lock
//  gameOver      out  1              sticky until Reset or startGame
//  lines         out  LINE_W         total rows cleared, saturating at 2**LINE_W-1
//  score         out  32             see CONFIGURATION
// BEHAVIOUR
//  Reset (async): fallenBlocks all 0, Spawn=lineBreak=gameOver=0, lines=0, score=0, state=IDLE.
//  States: IDLE, MERGE, SCAN, SHIFT, CHECK, DEAD. Row index r, per-lock clear count k (0..4, saturating at 7).
//  IDLE: startGame -> board/lines/score/gameOver cleared, Spawn=1 next cycle, stay IDLE.
//        else fell -> latch currBlocks, k=0 -> MERGE. fell outside IDLE is ignored.
//  MERGE: board <= board | latch; any bit of (board & latch) set -> gameOver flag; r=ROWS-1 -> SCAN.
//  SCAN: row r == all ones -> SHIFT; else r==0 -> CHECK; else r<=r-1.
//  SHIFT: rows 1..r <= rows 0..r-1, row 0 <= 0; lines+1 (sat.), k+1; r unchanged -> SCAN (rescan same row).
//  CHECK: gameOver flag set or any of rows 0..SPAWN_ROWS-1 nonzero -> gameOver=1, no Spawn -> DEAD;
//         else Spawn=1 and lineBreak=(k!=0) for exactly the next cycle -> IDLE.
//  DEAD: holds board; fell ignored; only startGame (as in IDLE, -> IDLE) or Reset leaves it.
//  Latency: edge sampling fell = edge 0; Spawn high after edge ROWS+2 (22 at default), +2 edges per cleared row.
//  startGame and fell in the same cycle: startGame wins, fell dropped.
//  startGame outside IDLE/DEAD: ignored (lock sequence completes first).
//  Reset mid-sequence: immediate return to reset values; no Spawn issued.
//  Spawn, lineBreak never high in any cycle other than the one after CHECK or after startGame.
// CONFIGURATION
//  BOARD_SCORE_EN defined: at CHECK score += {0,40,100,300,1200}[k] (k>4 treated as 4), saturating at 2**32-1;
//   cleared by startGame/Reset.
//  BOARD_SCORE_EN undefined: no scoring logic; score tied to 0.
// TESTING
//  1 Reset pulse -> all outputs 0, fallenBlocks all 0; fell then accepted normally.
//  2 Empty board, currBlocks[19]=10'h00F, fell 1 cycle -> Spawn high exactly after edge 22, lineBreak=0,
//    fallenBlocks[19]=10'h00F, lines=0.
//  3 Board row19=10'h3F0, row18=10'h001; drop currBlocks[19]=10'h00F -> Spawn after edge 24, lineBreak=1,
//    row19=10'h001, row18=0, lines=1 (score=40 with BOARD_SCORE_EN).
//  4 Rows 16..19=10'h3FE, drop column-0 I piece (bit0 rows 16..19) -> Spawn after edge 30, lines=4,
//    board empty, score=1200 with BOARD_SCORE_EN, 0 without.
//  5 Lock leaving row 1 nonzero -> gameOver=1, no Spawn, later fell ignored;
//    startGame -> board 0, gameOver=0, Spawn pulse next cycle.
//  6 Reset asserted during SCAN (edge 10 of test 3) -> outputs clear that cycle; no Spawn/lineBreak afterwards.

Source files
------------

// File: rtl/board_lock_clear.sv
// board_lock_clear: merges a landed piece into the settled board. It then clears
// full rows one at a time, bottom-up, and either requests the next piece (Spawn) or
// ends the game.
// Optional feature: define BOARD_SCORE_EN to enable the per-lock score accumulator.
// If it is not defined, score is tied to zero.
module board_lock_clear #(
    parameter int ROWS       = 20,
    parameter int COLS       = 10,
    parameter int SPAWN_ROWS = 2,
    parameter int LINE_W     = 16
) (
    input  logic                          frame_clk,
    input  logic                          Reset,
    input  logic                          startGame,
    input  logic                          fell,
    input  logic [ROWS-1:0][COLS-1:0]     currBlocks,
    output logic [ROWS-1:0][COLS-1:0]     fallenBlocks,
    output logic                          Spawn,
    output logic                          lineBreak,
    output logic                          gameOver,
    output logic [LINE_W-1:0]             lines,
    output logic [31:0]                   score
);

    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [2:0] {IDLE, MERGE, SCAN, SHIFT, CHECK, DEAD} state_t;

    state_t                      state;
    logic [ROWS-1:0][COLS-1:0]   board;
    logic [ROWS-1:0][COLS-1:0]   latch;
    logic [ROW_W-1:0]            r;
    logic [2:0]                  k;
    logic                        over_flag;
    logic                        top_busy;

    assign fallenBlocks = board;

    // Any cell occupied in the spawn area means the next piece cannot enter.
    always_comb begin
        // NOTE: give every always_comb output a default first so that no path leaves it unassigned and infers a latch.
        top_busy = 1'b0;
        for (int i = 0; i < SPAWN_ROWS; i++) begin
            top_busy = top_busy | (|board[i]);
        end
    end

    // Lock sequencer: merge, scan/shift full rows bottom-up, then spawn or die.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            // NOTE: the board is reset in full because it is architectural game state, not a RAM that may power up as garbage.
            board     <= '0;
            latch     <= '0;
            r         <= '0;
            k         <= '0;
            over_flag <= 1'b0;
            Spawn     <= 1'b0;
            lineBreak <= 1'b0;
            gameOver  <= 1'b0;
            lines     <= '0;
        end else begin
            // NOTE: non-blocking assignments everywhere here so that every register samples the pre-edge values of the others.
            Spawn     <= 1'b0;
            lineBreak <= 1'b0;
            case (state)
                IDLE, DEAD: begin
                    if (startGame) begin
                        board     <= '0;
                        lines     <= '0;
                        gameOver  <= 1'b0;
                        over_flag <= 1'b0;
                        Spawn     <= 1'b1;
                        state     <= IDLE;
                    end else if (state == IDLE && fell) begin
                        latch     <= currBlocks;
                        k         <= '0;
                        over_flag <= 1'b0;
                        state     <= MERGE;
                    end
                end
                MERGE: begin
                    board <= board | latch;
                    if (|(board & latch)) begin
                        over_flag <= 1'b1;
                    end
                    r     <= ROW_W'(ROWS - 1);
                    state <= SCAN;
                end
                SCAN: begin
                    if (board[r] == '1) begin
                        state <= SHIFT;
                    end else if (r == '0) begin
                        state <= CHECK;
                    end else begin
                        r <= r - 1'b1;
                    end
                end
                SHIFT: begin
                    // Everything above the full row drops by one and row r is rescanned.
                    for (int i = 1; i < ROWS; i++) begin
                        if (ROW_W'(i) <= r) begin
                            board[i] <= board[i-1];
                        end
                    end
                    board[0] <= '0;
                    if (lines != '1) begin
                        lines <= lines + 1'b1;
                    end
                    if (k != 3'd7) begin
                        k <= k + 3'd1;
                    end
                    state <= SCAN;
                end
                CHECK: begin
                    if (over_flag || top_busy) begin
                        gameOver <= 1'b1;
                        state    <= DEAD;
                    end else begin
                        Spawn     <= 1'b1;
                        lineBreak <= (k != 3'd0);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BOARD_SCORE_EN
    logic [31:0] score_q;
    logic [31:0] score_inc;
    logic [32:0] score_sum;

    // Points for this lock, indexed by rows cleared; four or more earn the maximum.
    always_comb begin
        score_inc = 32'd0;
        case (k)
            3'd0:    score_inc = 32'd0;
            3'd1:    score_inc = 32'd40;
            3'd2:    score_inc = 32'd100;
            3'd3:    score_inc = 32'd300;
            default: score_inc = 32'd1200;
        endcase
        score_sum = {1'b0, score_q} + {1'b0, score_inc};
    end

    // Score accumulator: cleared with the board, updated once per lock, saturating.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            score_q <= '0;
        end else if ((state == IDLE || state == DEAD) && startGame) begin
            score_q <= '0;
        end else if (state == CHECK) begin
            score_q <= score_sum[32] ? '1 : score_sum[31:0];
        end
    end

    assign score = score_q;
`else
    assign score = 32'd0;
`endif

endmodule

// File: tb/tb_board_lock_clear.sv
// Directed bench for board_lock_clear: lock latency, row clearing, game over,
// startGame priority and asynchronous reset in the middle of a lock.
module tb_board_lock_clear;

    localparam int ROWS = 20;
    localparam int COLS = 10;

    logic                        frame_clk = 1'b0;
    logic                        Reset;
    logic                        startGame;
    logic                        fell;
    logic [ROWS-1:0][COLS-1:0]   currBlocks;
    logic [ROWS-1:0][COLS-1:0]   fallenBlocks;
    logic                        Spawn;
    logic                        lineBreak;
    logic                        gameOver;
    logic [15:0]                 lines;
    logic [31:0]                 score;

    int n_cmp  = 0;
    int n_fail = 0;

    board_lock_clear dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .startGame    (startGame),
        .fell         (fell),
        .currBlocks   (currBlocks),
        .fallenBlocks (fallenBlocks),
        .Spawn        (Spawn),
        .lineBreak    (lineBreak),
        .gameOver     (gameOver),
        .lines        (lines),
        .score        (score)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    // Pulse fell with a piece; count edges after edge 0 until Spawn or gameOver (bounded).
    task automatic run_lock(input logic [ROWS-1:0][COLS-1:0] piece,
                            output int edges, output logic spawn_seen, output logic lb_seen);
        currBlocks = piece;
        fell       = 1'b1;
        tick(1);
        fell       = 1'b0;
        currBlocks = '0;
        edges      = 0;
        while (edges < 60) begin
            tick(1);
            edges++;
            if (Spawn || gameOver) break;
        end
        spawn_seen = Spawn;
        lb_seen    = lineBreak;
    endtask

    // Watch n edges and count Spawn / lineBreak pulses.
    task automatic watch(input int n, output int spawns, output int lbs);
        spawns = 0;
        lbs    = 0;
        repeat (n) begin
            tick(1);
            if (Spawn)     spawns++;
            if (lineBreak) lbs++;
        end
    endtask

    task automatic start_game();
        startGame = 1'b1;
        tick(1);
        startGame = 1'b0;
    endtask

    logic [ROWS-1:0][COLS-1:0] piece;
    logic [ROWS-1:0][COLS-1:0] exp_b;
    int                        edges;
    logic                      sp;
    logic                      lb;
    int                        n_sp;
    int                        n_lb;
    logic [31:0]               exp_score;

    initial begin
        Reset      = 1'b1;
        startGame  = 1'b0;
        fell       = 1'b0;
        currBlocks = '0;

        // 1: reset state
        tick(2);
        check("rst_spawn",    200'(Spawn),     200'(0));
        check("rst_linebrk",  200'(lineBreak), 200'(0));
        check("rst_gameover", 200'(gameOver),  200'(0));
        check("rst_lines",    200'(lines),     200'(0));
        check("rst_score",    200'(score),     200'(0));
        check("rst_board",    fallenBlocks,    200'(0));
        Reset = 1'b0;
        tick(1);

        // 2: single piece onto an empty board
        piece = '0;
        piece[19] = 10'h00F;
        run_lock(piece, edges, sp, lb);
        exp_b = '0;
        exp_b[19] = 10'h00F;
        check("t2_edges",   200'(edges), 200'(22));
        check("t2_spawn",   200'(sp),    200'(1));
        check("t2_linebrk", 200'(lb),    200'(0));
        check("t2_board",   fallenBlocks, exp_b);
        check("t2_lines",   200'(lines), 200'(0));
        tick(1);
        check("t2_spawn_one_cycle", 200'(Spawn), 200'(0));

        // startGame clears the board and spawns the next cycle
        start_game();
        check("sg_spawn", 200'(Spawn), 200'(1));
        check("sg_board", fallenBlocks, 200'(0));
        tick(1);
        check("sg_spawn_one_cycle", 200'(Spawn), 200'(0));

        // 3: one row cleared
        piece = '0;
        piece[19] = 10'h3F0;
        piece[18] = 10'h001;
        run_lock(piece, edges, sp, lb);
        check("t3_setup_edges", 200'(edges), 200'(22));
        piece = '0;
        piece[19] = 10'h00F;
        run_lock(piece, edges, sp, lb);
        exp_b = '0;
        exp_b[19] = 10'h001;
`ifdef BOARD_SCORE_EN
        exp_score = 32'd40;
`else
        exp_score = 32'd0;
`endif
        check("t3_edges",   200'(edges), 200'(24));
        check("t3_spawn",   200'(sp),    200'(1));
        check("t3_linebrk", 200'(lb),    200'(1));
        check("t3_board",   fallenBlocks, exp_b);
        check("t3_lines",   200'(lines), 200'(1));
        check("t3_score",   200'(score), 200'(exp_score));
        tick(1);
        check("t3_linebrk_one_cycle", 200'(lineBreak), 200'(0));

        // startGame and fell together: startGame wins, the piece is dropped
        piece = '0;
        piece[19] = 10'h3FF;
        currBlocks = piece;
        fell       = 1'b1;
        startGame  = 1'b1;
        tick(1);
        fell       = 1'b0;
        startGame  = 1'b0;
        currBlocks = '0;
        check("sgf_spawn", 200'(Spawn), 200'(1));
        check("sgf_lines", 200'(lines), 200'(0));
        watch(30, n_sp, n_lb);
        check("sgf_no_lock",  200'(n_sp), 200'(0));
        check("sgf_board",    fallenBlocks, 200'(0));

        // 4: four rows cleared by a vertical I piece
        piece = '0;
        for (int i = 16; i < 20; i++) piece[i] = 10'h3FE;
        run_lock(piece, edges, sp, lb);
        check("t4_setup_edges", 200'(edges), 200'(22));
        piece = '0;
        for (int i = 16; i < 20; i++) piece[i] = 10'h001;
        run_lock(piece, edges, sp, lb);
`ifdef BOARD_SCORE_EN
        exp_score = 32'd1200;
`else
        exp_score = 32'd0;
`endif
        check("t4_edges",   200'(edges), 200'(30));
        check("t4_linebrk", 200'(lb),    200'(1));
        check("t4_board",   fallenBlocks, 200'(0));
        check("t4_lines",   200'(lines), 200'(4));
        check("t4_score",   200'(score), 200'(exp_score));

        // 5: lock leaving row 1 occupied ends the game
        piece = '0;
        piece[1] = 10'h010;
        run_lock(piece, edges, sp, lb);
        exp_b = piece;
        check("t5_edges",    200'(edges),    200'(22));
        check("t5_no_spawn", 200'(sp),       200'(0));
        check("t5_gameover", 200'(gameOver), 200'(1));
        piece = '0;
        piece[19] = 10'h3FF;
        currBlocks = piece;
        fell       = 1'b1;
        tick(1);
        fell       = 1'b0;
        currBlocks = '0;
        watch(30, n_sp, n_lb);
        check("t5_dead_no_spawn", 200'(n_sp),     200'(0));
        check("t5_dead_board",    fallenBlocks,   exp_b);
        check("t5_dead_sticky",   200'(gameOver), 200'(1));
        start_game();
        check("t5_sg_spawn",    200'(Spawn),    200'(1));
        check("t5_sg_gameover", 200'(gameOver), 200'(0));
        check("t5_sg_board",    fallenBlocks,   200'(0));
        check("t5_sg_lines",    200'(lines),    200'(0));

        // 6: asynchronous reset in the middle of the test-3 lock
        piece = '0;
        piece[19] = 10'h3F0;
        piece[18] = 10'h001;
        run_lock(piece, edges, sp, lb);
        check("t6_setup_edges", 200'(edges), 200'(22));
        piece = '0;
        piece[19] = 10'h00F;
        currBlocks = piece;
        fell       = 1'b1;
        tick(1);
        fell       = 1'b0;
        currBlocks = '0;
        tick(9);
        Reset = 1'b1;
        #1;
        check("t6_rst_lines",    200'(lines),     200'(0));
        check("t6_rst_board",    fallenBlocks,    200'(0));
        check("t6_rst_spawn",    200'(Spawn),     200'(0));
        check("t6_rst_gameover", 200'(gameOver),  200'(0));
        check("t6_rst_score",    200'(score),     200'(0));
        tick(1);
        Reset = 1'b0;
        watch(40, n_sp, n_lb);
        check("t6_no_spawn",   200'(n_sp), 200'(0));
        check("t6_no_linebrk", 200'(n_lb), 200'(0));

        // fell accepted normally after reset
        piece = '0;
        piece[19] = 10'h00F;
        run_lock(piece, edges, sp, lb);
        exp_b = piece;
        check("t6_after_edges", 200'(edges), 200'(22));
        check("t6_after_board", fallenBlocks, exp_b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
